// File: rtl/dice_result_stabilizer.sv
// Qualifies per-frame dice detections into a single dice_valid pulse per physical roll.
// A value must repeat over consecutive frames; re-arming needs the die to be absent for a while.
module dice_result_stabilizer #(
    parameter int STABLE_FRAMES = 4,
    parameter int MISS_TOL      = 1,
    parameter int REARM_FRAMES  = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       frame_done,
    input  logic       det_valid,
    input  logic [1:0] det_value,
    output logic       dice_valid,
    output logic [1:0] dice_value,
    output logic [1:0] state,
    output logic [3:0] stable_cnt
);

    localparam logic [1:0] ARMED  = 2'b00;
    localparam logic [1:0] TRACK  = 2'b01;
    localparam logic [1:0] LOCKED = 2'b10;

    localparam logic [3:0] STABLE_N = 4'(STABLE_FRAMES);
    localparam logic [2:0] MISS_N   = 3'(MISS_TOL);
    localparam logic [3:0] REARM_N  = 4'(REARM_FRAMES);

    logic [1:0] cand;
    logic [2:0] miss_cnt;
    logic [3:0] clr_cnt;
    logic [3:0] stable_nxt;
    logic [3:0] clr_nxt;
    logic       frame;
    logic       accept;

    assign stable_nxt = stable_cnt + 4'd1;
    assign clr_nxt    = clr_cnt + 4'd1;
    assign frame      = enable & frame_done;

    // A single-frame threshold accepts straight from ARMED; otherwise only a matching TRACK frame can.
    assign accept = frame & det_valid &
                    (((state == ARMED) && (STABLE_N == 4'd1)) ||
                     ((state == TRACK) && (det_value == cand) && (stable_nxt == STABLE_N)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ARMED;
            cand       <= 2'd0;
            stable_cnt <= 4'd0;
            miss_cnt   <= 3'd0;
            clr_cnt    <= 4'd0;
            dice_valid <= 1'b0;
            dice_value <= 2'd0;
        end else begin
            dice_valid <= 1'b0;
            if (!enable) begin
                state      <= ARMED;
                stable_cnt <= 4'd0;
                miss_cnt   <= 3'd0;
                clr_cnt    <= 4'd0;
            end else if (accept) begin
                dice_valid <= 1'b1;
                dice_value <= det_value;
                cand       <= det_value;
                state      <= LOCKED;
                stable_cnt <= 4'd0;
                miss_cnt   <= 3'd0;
                clr_cnt    <= 4'd0;
            end else if (frame) begin
                case (state)
                    ARMED: begin
                        if (det_valid) begin
                            cand       <= det_value;
                            stable_cnt <= 4'd1;
                            miss_cnt   <= 3'd0;
                            state      <= TRACK;
                        end
                    end
                    TRACK: begin
                        if (det_valid && det_value == cand) begin
                            stable_cnt <= stable_nxt;
                            miss_cnt   <= 3'd0;
                        end else if (det_valid) begin
                            cand       <= det_value;
                            stable_cnt <= 4'd1;
                            miss_cnt   <= 3'd0;
                        end else if (miss_cnt < MISS_N) begin
                            miss_cnt <= miss_cnt + 3'd1;
                        end else begin
                            state      <= ARMED;
                            stable_cnt <= 4'd0;
                            miss_cnt   <= 3'd0;
                        end
                    end
                    LOCKED: begin
                        // Any sighting restarts the absence count, so a die left in view never re-fires.
                        if (det_valid) begin
                            clr_cnt <= 4'd0;
                        end else if (clr_nxt == REARM_N) begin
                            state   <= ARMED;
                            clr_cnt <= 4'd0;
                        end else begin
                            clr_cnt <= clr_nxt;
                        end
                    end
                    default: begin
                        state      <= ARMED;
                        stable_cnt <= 4'd0;
                        miss_cnt   <= 3'd0;
                        clr_cnt    <= 4'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dice_result_stabilizer.sv
// Directed and randomized checks of dice_result_stabilizer against a frame-level roll model.
module tb_dice_result_stabilizer;

    localparam int SF = 4;
    localparam int MT = 1;
    localparam int RF = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       frame_done;
    logic       det_valid;
    logic [1:0] det_value;
    logic       dice_valid;
    logic [1:0] dice_value;
    logic [1:0] state;
    logic [3:0] stable_cnt;

    int total = 0;
    int bad   = 0;

    // Reference model: phase 0 waiting for a die, 1 counting a run, 2 holding a result.
    int m_phase, m_cand, m_run, m_gap, m_away, m_pulse, m_value;

    dice_result_stabilizer #(.STABLE_FRAMES(SF), .MISS_TOL(MT), .REARM_FRAMES(RF)) dut (
        .clk(clk), .reset(reset), .enable(enable), .frame_done(frame_done),
        .det_valid(det_valid), .det_value(det_value), .dice_valid(dice_valid),
        .dice_value(dice_value), .state(state), .stable_cnt(stable_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_cand = 0; m_run = 0; m_gap = 0; m_away = 0;
        m_pulse = 0; m_value = 0;
    endtask

    task automatic model_frame(input bit en, input bit fd, input bit dv, input int val);
        m_pulse = 0;
        if (!en) begin
            m_phase = 0; m_run = 0; m_gap = 0; m_away = 0;
        end else if (fd) begin
            if (m_phase == 2) begin
                m_away = dv ? 0 : m_away + 1;
                if (m_away == RF) begin m_phase = 0; m_away = 0; end
            end else if (dv) begin
                m_run  = (m_phase == 1 && val == m_cand) ? m_run + 1 : 1;
                m_cand = val;
                m_gap  = 0;
                m_phase = 1;
                if (m_run == SF) begin
                    m_pulse = 1; m_value = val; m_phase = 2; m_run = 0; m_away = 0;
                end
            end else if (m_phase == 1) begin
                if (m_gap < MT) m_gap++;
                else begin m_phase = 0; m_run = 0; m_gap = 0; end
            end
        end
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".valid"}, int'(dice_valid), m_pulse);
        chk({tag, ".value"}, int'(dice_value), m_value);
        chk({tag, ".state"}, int'(state), m_phase);
        chk({tag, ".cnt"},   int'(stable_cnt), m_run);
    endtask

    task automatic step(input bit en, input bit fd, input bit dv, input int val, input string tag);
        enable = en; frame_done = fd; det_valid = dv; det_value = 2'(val);
        @(posedge clk);
        model_frame(en, fd, dv, val);
        #1;
        compare_all(tag);
        enable = 1'b1; frame_done = 1'b0; det_valid = 1'b0; det_value = 2'd0;
    endtask

    task automatic fr(input bit dv, input int val, input string tag);
        step(1'b1, 1'b1, dv, val, tag);
        step(1'b1, 1'b0, 1'b0, 0, {tag, ".gap"});
    endtask

    initial begin
        int prev;
        reset = 1'b0; enable = 1'b1; frame_done = 1'b0; det_valid = 1'b0; det_value = 2'd0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all("rst");
        reset = 1'b1;

        // four frames of 2 -> one pulse right after the 4th frame
        for (int i = 0; i < 3; i++) fr(1'b1, 2, "s1");
        step(1'b1, 1'b1, 1'b1, 2, "s1.last");
        chk("s1.pulse", int'(dice_valid), 1);
        chk("s1.val", int'(dice_value), 2);
        chk("s1.locked", int'(state), 2);
        step(1'b1, 1'b0, 1'b0, 0, "s1.after");
        chk("s1.single", int'(dice_valid), 0);
        for (int i = 0; i < RF; i++) fr(1'b0, 0, "s1.clr");

        // 1,1,3,3,3,3 -> candidate restarts, accepted value 3
        fr(1'b1, 1, "s2"); fr(1'b1, 1, "s2");
        fr(1'b1, 3, "s2");
        chk("s2.restart", int'(stable_cnt), 1);
        fr(1'b1, 3, "s2"); fr(1'b1, 3, "s2");
        step(1'b1, 1'b1, 1'b1, 3, "s2.last");
        chk("s2.pulse", int'(dice_valid), 1);
        chk("s2.val", int'(dice_value), 3);
        for (int i = 0; i < RF; i++) step(1'b1, 1'b1, 1'b0, 0, "s2.clr");

        // 2,2,none,2,2 -> one miss tolerated
        fr(1'b1, 2, "s3"); fr(1'b1, 2, "s3"); fr(1'b0, 0, "s3"); fr(1'b1, 2, "s3");
        step(1'b1, 1'b1, 1'b1, 2, "s3.last");
        chk("s3.pulse", int'(dice_valid), 1);
        for (int i = 0; i < RF; i++) fr(1'b0, 0, "s3.clr");
        // 2,2,none,none -> aborted
        fr(1'b1, 2, "s3b"); fr(1'b1, 2, "s3b"); fr(1'b0, 0, "s3b"); fr(1'b0, 0, "s3b");
        chk("s3b.armed", int'(state), 0);
        chk("s3b.cnt", int'(stable_cnt), 0);

        // accept, die stays, rearm rule, second roll of 0
        for (int i = 0; i < SF; i++) fr(1'b1, 1, "s4.acc");
        for (int i = 0; i < 10; i++) fr(1'b1, 1, "s4.stay");
        fr(1'b0, 0, "s4"); fr(1'b0, 0, "s4"); fr(1'b1, 1, "s4");
        fr(1'b0, 0, "s4"); fr(1'b0, 0, "s4");
        chk("s4.still_locked", int'(state), 2);
        fr(1'b0, 0, "s4");
        chk("s4.armed", int'(state), 0);
        for (int i = 0; i < SF - 1; i++) fr(1'b1, 0, "s4.zero");
        step(1'b1, 1'b1, 1'b1, 0, "s4.zero_last");
        chk("s4.pulse2", int'(dice_valid), 1);
        chk("s4.val0", int'(dice_value), 0);
        for (int i = 0; i < RF; i++) fr(1'b0, 0, "s4.clr");

        // enable drop mid-TRACK, frames ignored while disabled
        for (int i = 0; i < 3; i++) fr(1'b1, 3, "s5");
        chk("s5.cnt3", int'(stable_cnt), 3);
        step(1'b0, 1'b0, 1'b0, 0, "s5.dis");
        chk("s5.armed", int'(state), 0);
        chk("s5.cnt0", int'(stable_cnt), 0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 3, "s5.ign");

        // async reset during the pulse
        for (int i = 0; i < SF - 1; i++) fr(1'b1, 1, "s6");
        step(1'b1, 1'b1, 1'b1, 1, "s6.last");
        chk("s6.pulse", int'(dice_valid), 1);
        #2 reset = 1'b0;
        model_reset();
        #1;
        chk("s6.rst_valid", int'(dice_valid), 0);
        chk("s6.rst_value", int'(dice_value), 0);
        chk("s6.rst_state", int'(state), 0);
        @(negedge clk) reset = 1'b1;
        for (int i = 0; i < SF - 1; i++) fr(1'b1, 2, "s6.re");
        step(1'b1, 1'b1, 1'b1, 2, "s6.re_last");
        chk("s6.re_pulse", int'(dice_valid), 1);

        // randomized frames, values biased toward repeats
        prev = 0;
        for (int i = 0; i < 600; i++) begin
            bit en, fd, dv;
            int v;
            en = ($urandom_range(0, 19) != 0);
            fd = ($urandom_range(0, 2) != 0);
            dv = ($urandom_range(0, 3) != 0);
            v  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : prev;
            prev = v;
            step(en, fd, dv, v, "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
